// File: rtl/flash_defs.sv
// Shared flash command codes, status register bit positions and arbiter state encoding.
package flash_defs;

  localparam logic [7:0] CMD_PROGRAM    = 8'h40;
  localparam logic [7:0] CMD_CLR_SR     = 8'h50;
  localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

  localparam int SR_READY    = 7;
  localparam int SR_PROG_ERR = 4;
  localparam int SR_VPP_ERR  = 3;
  localparam int SR_LOCK_ERR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMD,
    S_DATA,
    S_POLL,
    S_CLRSR,
    S_RESTORE,
    S_ACK
  } state_t;

  function automatic logic status_error(input logic [7:0] sr);
    return sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the pointed-to port.
module flash_rr_arb (
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic grant_id,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 && req1) ? pointer : req1;

endmodule

// File: rtl/flash_arbiter.sv
// Two-port flash arbiter: grants one port at a time and sequences its read or
// program operation (command, data, status poll, error clear, read-array restore).
module flash_arbiter
  import flash_defs::*;
#(
  parameter logic [15:0] POLL_MAX = 16'd50000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       fail,
  output logic [7:0] addr,
  output logic [7:0] data_w,
  output logic       direction_rw,
  output logic       fb_action,
  input  logic       fb_done,
  input  logic [7:0] data_r
);

  state_t      state;
  logic        rr_ptr;
  logic        port;
  logic        issued;
  logic [7:0]  op_wdata;
  logic [15:0] poll_cnt;
  logic        grant_id;
  logic        grant_valid;
  logic        sel_rw;
  logic [7:0]  sel_addr;
  logic [7:0]  sel_wdata;

  flash_rr_arb u_rr (
    .req0       (req0),
    .req1       (req1),
    .pointer    (rr_ptr),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  assign sel_rw    = grant_id ? rw1    : rw0;
  assign sel_addr  = grant_id ? addr1  : addr0;
  assign sel_wdata = grant_id ? wdata1 : wdata0;

  // Bus fields are loaded on entry to a bus state; the strobe follows one cycle later.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      port         <= 1'b0;
      issued       <= 1'b0;
      op_wdata     <= 8'h00;
      poll_cnt     <= 16'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= 8'h00;
      fail         <= 1'b0;
      addr         <= 8'h00;
      data_w       <= 8'h00;
      direction_rw <= 1'b0;
      fb_action    <= 1'b0;
    end else begin
      fb_action <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            port     <= grant_id;
            rr_ptr   <= ~grant_id;
            addr     <= sel_addr;
            op_wdata <= sel_wdata;
            fail     <= 1'b0;
            poll_cnt <= 16'd0;
            issued   <= 1'b0;
            if (sel_rw) begin
              direction_rw <= 1'b1;
              data_w       <= CMD_PROGRAM;
              state        <= S_CMD;
            end else begin
              direction_rw <= 1'b0;
              state        <= S_READ;
            end
          end
        end
        S_ACK: state <= S_IDLE;
        default: begin
          if (!issued) begin
            fb_action <= 1'b1;
            issued    <= 1'b1;
          end else if (fb_done) begin
            issued <= 1'b0;
            case (state)
              S_READ: begin
                rdata <= data_r;
                fail  <= 1'b0;
                ack0  <= ~port;
                ack1  <= port;
                state <= S_ACK;
              end
              S_CMD: begin
                data_w <= op_wdata;
                state  <= S_DATA;
              end
              S_DATA: begin
                direction_rw <= 1'b0;
                state        <= S_POLL;
              end
              S_POLL: begin
                if (!data_r[SR_READY]) begin
                  poll_cnt <= poll_cnt + 16'd1;
                  if (poll_cnt + 16'd1 == POLL_MAX) begin
                    fail         <= 1'b1;
                    direction_rw <= 1'b1;
                    data_w       <= CMD_CLR_SR;
                    state        <= S_CLRSR;
                  end
                end else if (status_error(data_r)) begin
                  fail         <= 1'b1;
                  direction_rw <= 1'b1;
                  data_w       <= CMD_CLR_SR;
                  state        <= S_CLRSR;
                end else begin
                  direction_rw <= 1'b1;
                  data_w       <= CMD_READ_ARRAY;
                  state        <= S_RESTORE;
                end
              end
              S_CLRSR: begin
                data_w <= CMD_READ_ARRAY;
                state  <= S_RESTORE;
              end
              S_RESTORE: begin
                ack0  <= ~port;
                ack1  <= port;
                state <= S_ACK;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter POLL_MAX, default 16'd50000, maximum status reads per program before timeout.
REQ-002 CLK_50MHZ  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  in  1  request from port 0 / port 1; held high until the matching ack.
REQ-005 rw0 / rw1  in  1  1 = program byte, 0 = read byte.
REQ-006 addr0 / addr1  in  8  flash byte address.
REQ-007 wdata0 / wdata1  in  8  byte to program; ignored on read.
REQ-008 ack0 / ack1  out  1  one-cycle completion pulse to the port.
REQ-009 rdata  out  8  read byte, valid in the ack cycle (read only).
REQ-010 fail  out  1  program error or timeout, valid in the ack cycle.
REQ-011 addr  out  8  address to the flash datapath.
REQ-012 data_w  out  8  byte to the flash datapath.
REQ-013 direction_rw  out  1  1 = bus write, 0 = bus read.
REQ-014 fb_action  out  1  one-cycle strobe; starts one flash bus cycle.
REQ-015 fb_done  in  1  one-cycle pulse from the datapath: bus cycle finished.
REQ-016 data_r  in  8  byte returned by the datapath, valid with fb_done.

Function
REQ-017 States: IDLE, READ, CMD, DATA, POLL, CLRSR, RESTORE, ACK.
REQ-018 Arbitration happens in IDLE only.
  - One req high: that port is granted.
  - Both high: port named by the rr pointer is granted.
  - The rr pointer then points to the other port.
REQ-019 At grant, rw/addr/wdata of the granted port are latched; later changes and req withdrawal are ignored until ack.
REQ-020 Every bus cycle: addr/data_w/direction_rw are set, then fb_action pulses exactly once, then the FSM waits for fb_done.
  - fb_action is never reasserted before fb_done.
  - fb_done arriving outside a wait is ignored.
REQ-021 Read: one bus read at the latched addr; data_r captured into rdata on fb_done; fail=0; go to ACK.
REQ-022 Program sequence (each step on fb_done):
  - CMD: write 8'h40 to the latched addr.
  - DATA: write wdata to the latched addr.
  - POLL: read status at the latched addr.
REQ-023 POLL completion:
  - SR[7]=0: increment the 16-bit poll counter and repeat POLL.
  - Counter reaches POLL_MAX: fail=1; go to CLRSR.
  - SR[7]=1: fail = SR[4]|SR[3]|SR[1]; go to CLRSR if fail, else RESTORE.
REQ-024 CLRSR writes 8'h50, then RESTORE. RESTORE writes 8'hFF (read-array mode), then ACK.
REQ-025 ACK: the granted port's ack pulses for one cycle; return to IDLE. Earliest re-grant is the cycle after ACK.
REQ-026 Latency: read completes 2 cycles after fb_done at the latest; back-to-back requests are never granted inside one operation.
REQ-027 rdata, fail and addr hold their values between operations.

Reset
REQ-028 RST high forces immediately, mid-operation included:
  - state IDLE, rr pointer = port 0.
  - ack0/ack1, fb_action, direction_rw, fail = 0.
  - addr, data_w, rdata = 0; poll counter = 0.
REQ-029 An operation interrupted by reset gets no ack; its requester must re-request.

Structure
REQ-030 A shared flash_defs package holds:
  - command constants 8'h40, 8'h50, 8'hFF.
  - status bit indices 7, 4, 3, 1.
  - state encoding.
REQ-031 The 2-way round-robin picker is a sub-module, flash_rr_arb (req0, req1, pointer -> grant_id, grant_valid); the remainder is one FSM.

Verification
REQ-032 Read, port 0, addr 8'h35, datapath returns 8'hC9 -> one fb_action with direction_rw=0 and addr=8'h35; ack0 pulse with rdata=8'hC9, fail=0.
REQ-033 Program, port 1, addr 8'h35, wdata 8'hC9; status 8'h00 twice, then 8'h80 -> bus writes 40, C9, three status reads, FF; ack1 with fail=0.
REQ-034 req0 and req1 raised in the same cycle, after reset -> port 0 served first, then port 1; a second simultaneous pair -> port 0 first again (pointer alternates per grant).
REQ-035 Program with status 8'h90 -> CLRSR writes 50, then FF; fail=1 with ack; POLL_MAX=4 with status always 8'h00 -> exactly 4 status reads, fail=1.
REQ-036 RST pulsed during DATA wait -> all outputs 0 within the same cycle; no ack; a late fb_done is ignored; a new request completes normally.
